// File: rtl/disp_scan_7seg_if.sv
// Display-side signal bundle for disp_scan_7seg: time inputs and blink enables in,
// multiplexed segment/anode drive and frame pulse out.
interface disp_scan_7seg_if;
  logic [5:0] horas;
  logic [5:0] minutos;
  logic [5:0] segundos;
  logic [2:0] blink_mask;
  logic [6:0] catodo;
  logic [7:0] anodo;
  logic       frame_done;

  modport master (
    output horas, minutos, segundos, blink_mask,
    input  catodo, anodo, frame_done
  );

  modport slave (
    input  horas, minutos, segundos, blink_mask,
    output catodo, anodo, frame_done
  );
endinterface

// File: rtl/disp_scan_7seg.sv
// Time-multiplexed 8-digit 7-segment scanner showing hh-mm-ss with per-group blink.
// Inputs are snapshotted once per frame and converted to BCD by a repeated-subtract FSM.
module disp_scan_7seg #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned BLINK_DIV   = 50000000
) (
  input  logic            clk,
  input  logic            reset_n,
  disp_scan_7seg_if.slave bus
);
  localparam int unsigned   SW        = $clog2(REFRESH_DIV);
  localparam int unsigned   BW        = $clog2(BLINK_DIV);
  localparam logic [SW-1:0] SLOT_MAX  = SW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);
  localparam logic [6:0]    SEG_DASH  = 7'b0111111;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SUB, S_STORE, S_DONE} state_t;

  logic [SW-1:0]   slot_q, slot_d;
  logic [2:0]      idx_q, idx_d;
  logic [BW-1:0]   blink_cnt_q, blink_cnt_d;
  logic            phase_q, phase_d;
  logic            init_q;
  logic [7:0]      anodo_q, anodo_d;
  logic [6:0]      catodo_q, catodo_d;
  logic            frame_done_q, frame_done_d;
  state_t          state_q, state_d;
  logic [1:0]      k_q, k_d;
  logic [5:0]      rem_q, rem_d;
  logic [3:0]      tens_q, tens_d;
  logic [5:0]      hh_q, hh_d, mm_q, mm_d, ss_q, ss_d;
  logic [2:0][3:0] stg_t_q, stg_t_d, stg_o_q, stg_o_d;
  logic [2:0][3:0] dsp_t_q, dsp_t_d, dsp_o_q, dsp_o_d;
  logic            tick, wrap, start;
  logic [3:0]      digit_val;
  logic            is_dash, grp_blink;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  // idx_q names the digit loaded on the next tick, so the first tick after reset shows digit 7
  always_comb begin
    tick  = (slot_q == SLOT_MAX);
    wrap  = tick && (idx_q == 3'd0);
    start = init_q || wrap;

    slot_d      = tick ? '0 : slot_q + SW'(1);
    blink_cnt_d = (blink_cnt_q == BLINK_MAX) ? '0 : blink_cnt_q + BW'(1);
    phase_d     = (blink_cnt_q == BLINK_MAX) ? ~phase_q : phase_q;

    digit_val = '0;
    is_dash   = 1'b0;
    grp_blink = 1'b0;
    case (idx_q)
      3'd7:    begin digit_val = dsp_t_q[0]; grp_blink = bus.blink_mask[2]; end
      3'd6:    begin digit_val = dsp_o_q[0]; grp_blink = bus.blink_mask[2]; end
      3'd4:    begin digit_val = dsp_t_q[1]; grp_blink = bus.blink_mask[1]; end
      3'd3:    begin digit_val = dsp_o_q[1]; grp_blink = bus.blink_mask[1]; end
      3'd1:    begin digit_val = dsp_t_q[2]; grp_blink = bus.blink_mask[0]; end
      3'd0:    begin digit_val = dsp_o_q[2]; grp_blink = bus.blink_mask[0]; end
      default: is_dash = 1'b1;
    endcase

    idx_d        = idx_q;
    anodo_d      = anodo_q;
    catodo_d     = catodo_q;
    frame_done_d = 1'b0;
    if (tick) begin
      idx_d        = idx_q - 3'd1;
      catodo_d     = is_dash ? SEG_DASH : seg7(digit_val);
      anodo_d      = (phase_q && grp_blink) ? '1 : ~(8'b1 << idx_q);
      frame_done_d = wrap;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    rem_d   = rem_q;
    tens_d  = tens_q;
    hh_d    = hh_q;
    mm_d    = mm_q;
    ss_d    = ss_q;
    stg_t_d = stg_t_q;
    stg_o_d = stg_o_q;
    dsp_t_d = dsp_t_q;
    dsp_o_d = dsp_o_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          hh_d    = bus.horas;
          mm_d    = bus.minutos;
          ss_d    = bus.segundos;
          k_d     = 2'd0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        case (k_q)
          2'd0:    rem_d = hh_q;
          2'd1:    rem_d = mm_q;
          default: rem_d = ss_q;
        endcase
        tens_d  = '0;
        state_d = S_SUB;
      end
      S_SUB: begin
        if (rem_q >= 6'd10) begin
          rem_d  = rem_q - 6'd10;
          tens_d = tens_q + 4'd1;
        end else begin
          state_d = S_STORE;
        end
      end
      S_STORE: begin
        stg_t_d[k_q] = tens_q;
        stg_o_d[k_q] = rem_q[3:0];
        if (k_q == 2'd2) begin
          state_d = S_DONE;
        end else begin
          k_d     = k_q + 2'd1;
          state_d = S_LOAD;
        end
      end
      S_DONE: begin
        dsp_t_d = stg_t_q;
        dsp_o_d = stg_o_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_q       <= '0;
      idx_q        <= 3'd7;
      blink_cnt_q  <= '0;
      phase_q      <= 1'b0;
      init_q       <= 1'b1;
      anodo_q      <= '1;
      catodo_q     <= '1;
      frame_done_q <= 1'b0;
      state_q      <= S_IDLE;
      k_q          <= '0;
      rem_q        <= '0;
      tens_q       <= '0;
      hh_q         <= '0;
      mm_q         <= '0;
      ss_q         <= '0;
      stg_t_q      <= '0;
      stg_o_q      <= '0;
      dsp_t_q      <= '0;
      dsp_o_q      <= '0;
    end else begin
      slot_q       <= slot_d;
      idx_q        <= idx_d;
      blink_cnt_q  <= blink_cnt_d;
      phase_q      <= phase_d;
      init_q       <= 1'b0;
      anodo_q      <= anodo_d;
      catodo_q     <= catodo_d;
      frame_done_q <= frame_done_d;
      state_q      <= state_d;
      k_q          <= k_d;
      rem_q        <= rem_d;
      tens_q       <= tens_d;
      hh_q         <= hh_d;
      mm_q         <= mm_d;
      ss_q         <= ss_d;
      stg_t_q      <= stg_t_d;
      stg_o_q      <= stg_o_d;
      dsp_t_q      <= dsp_t_d;
      dsp_o_q      <= dsp_o_d;
    end
  end

  assign bus.anodo      = anodo_q;
  assign bus.catodo     = catodo_q;
  assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_disp_scan_7seg.sv
// Bench for disp_scan_7seg with REFRESH_DIV=8, BLINK_DIV=16: vector table of fixed displays
// plus sequences for mid-frame input change, reset during conversion and fast-toggling input.
module tb_disp_scan_7seg;
  localparam int unsigned RD    = 8;
  localparam int unsigned BD    = 16;
  localparam int unsigned FRAME = 8 * RD;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  disp_scan_7seg_if intf ();

  disp_scan_7seg #(.REFRESH_DIV(RD), .BLINK_DIV(BD)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (intf)
  );

  // clock edges seen since the last reset release
  int unsigned cyc;
  always @(posedge clk or negedge reset_n)
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  bit fd_mon = 1'b0;

  typedef struct {
    int unsigned edge_n;
    logic [7:0]  an;
    logic [6:0]  cat;
  } slot_t;
  slot_t sb_q[$];

  typedef struct {
    logic [5:0]        h, m, s;
    logic [2:0]        mask;
    logic [0:7][6:0]   cat;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] seg_ref(input int unsigned v);
    case (v)
      0: seg_ref = 7'h40; 1: seg_ref = 7'h79; 2: seg_ref = 7'h24; 3: seg_ref = 7'h30;
      4: seg_ref = 7'h19; 5: seg_ref = 7'h12; 6: seg_ref = 7'h02; 7: seg_ref = 7'h78;
      8: seg_ref = 7'h00; default: seg_ref = 7'h10;
    endcase
  endfunction

  function automatic logic [0:7][6:0] frame_cat(input int unsigned h, m, s);
    logic [0:7][6:0] c;
    c[0] = seg_ref(h / 10); c[1] = seg_ref(h % 10); c[2] = 7'h3F;
    c[3] = seg_ref(m / 10); c[4] = seg_ref(m % 10); c[5] = 7'h3F;
    c[6] = seg_ref(s / 10); c[7] = seg_ref(s % 10);
    return c;
  endfunction

  task automatic wait_edge(input int unsigned e);
    int unsigned guard = 0;
    while (cyc < e && guard < 4000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != e) begin
      checks++;
      errors++;
      $display("FAIL wait_edge: got cyc %0d, expected %0d", cyc, e);
    end
  endtask

  task automatic set_in(input logic [5:0] h, m, s, input logic [2:0] mask);
    intf.horas = h; intf.minutos = m; intf.segundos = s; intf.blink_mask = mask;
  endtask

  task automatic do_reset(input logic [5:0] h, m, s, input logic [2:0] mask);
    @(negedge clk);
    reset_n = 1'b0;
    set_in(h, m, s, mask);
    #1;
    chk("rst_anodo", intf.anodo, 8'hFF);
    chk("rst_catodo", intf.catodo, 7'h7F);
    chk("rst_frame_done", intf.frame_done, 1'b0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // push the 8 expected slots of frame j, then consume them as the DUT presents each slot
  task automatic check_frame(input int unsigned j, input logic [0:7][6:0] cat,
                             input logic [2:0] mask, input string tag);
    slot_t s;
    for (int unsigned p = 0; p < 8; p++) begin
      int unsigned e  = FRAME * j + RD + RD * p;
      int unsigned d  = 7 - p;
      bit          ph = (((e - 1) / BD) % 2) == 1;
      bit          bl;
      case (p)
        0, 1:    bl = mask[2];
        3, 4:    bl = mask[1];
        6, 7:    bl = mask[0];
        default: bl = 1'b0;
      endcase
      s.edge_n = e;
      s.cat    = cat[p];
      s.an     = (ph && bl) ? 8'hFF : ~(8'h01 << d);
      sb_q.push_back(s);
    end
    while (sb_q.size() > 0) begin
      s = sb_q.pop_front();
      wait_edge(s.edge_n);
      chk($sformatf("%s_anodo_e%0d", tag, s.edge_n), intf.anodo, s.an);
      chk($sformatf("%s_catodo_e%0d", tag, s.edge_n), intf.catodo, s.cat);
    end
  endtask

  always @(negedge clk)
    if (fd_mon)
      chk($sformatf("frame_done_c%0d", cyc), intf.frame_done,
          (reset_n && cyc != 0 && (cyc % FRAME) == 0) ? 1 : 0);

  initial begin
    tbl[0] = '{6'd12, 6'd34, 6'd56, 3'b000, {7'h79, 7'h24, 7'h3F, 7'h30, 7'h19, 7'h3F, 7'h12, 7'h02}};
    tbl[1] = '{6'd63, 6'd0,  6'd9,  3'b000, {7'h02, 7'h30, 7'h3F, 7'h40, 7'h40, 7'h3F, 7'h40, 7'h10}};
    tbl[2] = '{6'd23, 6'd59, 6'd7,  3'b000, {7'h24, 7'h30, 7'h3F, 7'h12, 7'h10, 7'h3F, 7'h40, 7'h78}};
    tbl[3] = '{6'd40, 6'd18, 6'd61, 3'b000, {7'h19, 7'h40, 7'h3F, 7'h79, 7'h00, 7'h3F, 7'h02, 7'h79}};
    tbl[4] = '{6'd12, 6'd34, 6'd56, 3'b001, {7'h79, 7'h24, 7'h3F, 7'h30, 7'h19, 7'h3F, 7'h12, 7'h02}};
    tbl[5] = '{6'd12, 6'd34, 6'd56, 3'b110, {7'h79, 7'h24, 7'h3F, 7'h30, 7'h19, 7'h3F, 7'h12, 7'h02}};
    tbl[6] = '{6'd12, 6'd34, 6'd56, 3'b111, {7'h79, 7'h24, 7'h3F, 7'h30, 7'h19, 7'h3F, 7'h12, 7'h02}};

    reset_n = 1'b1;
    set_in(6'd12, 6'd34, 6'd56, 3'b000);
    #2 reset_n = 1'b0;

    // reset values and first visible digit
    do_reset(6'd12, 6'd34, 6'd56, 3'b000);
    fd_mon = 1'b1;
    wait_edge(RD - 1);
    chk("pre_tick_anodo", intf.anodo, 8'hFF);
    chk("pre_tick_catodo", intf.catodo, 7'h7F);
    wait_edge(RD);
    chk("first_digit_anodo", intf.anodo, 8'h7F);

    for (int unsigned i = 0; i < 7; i++) begin
      do_reset(tbl[i].h, tbl[i].m, tbl[i].s, tbl[i].mask);
      check_frame(1, tbl[i].cat, tbl[i].mask, $sformatf("vec%0d_f1", i));
      check_frame(2, tbl[i].cat, tbl[i].mask, $sformatf("vec%0d_f2", i));
    end

    // seconds change mid-frame: current frame keeps 56, next frame shows 57
    do_reset(6'd12, 6'd34, 6'd56, 3'b000);
    fork
      check_frame(1, frame_cat(12, 34, 56), 3'b000, "midchg_f1");
      begin
        wait_edge(100);
        intf.segundos = 6'd57;
      end
    join
    check_frame(2, frame_cat(12, 34, 57), 3'b000, "midchg_f2");

    // reset while the converter is subtracting
    do_reset(6'd63, 6'd63, 6'd63, 3'b000);
    wait_edge(FRAME + 3);
    chk("pre_abort_anodo", intf.anodo, 8'hFE);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_anodo", intf.anodo, 8'hFF);
    chk("abort_catodo", intf.catodo, 7'h7F);
    chk("abort_frame_done", intf.frame_done, 1'b0);
    set_in(6'd7, 6'd45, 6'd38, 3'b000);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    check_frame(1, frame_cat(7, 45, 38), 3'b000, "abort_f1");
    check_frame(2, frame_cat(7, 45, 38), 3'b000, "abort_f2");

    // minutes toggling every 5 clk: each frame shows one whole snapshot
    do_reset(6'd23, 6'd17, 6'd5, 3'b000);
    fork
      begin
        check_frame(1, frame_cat(23, 17, 5), 3'b000, "toggle_f1");
        check_frame(2, frame_cat(23, 42, 5), 3'b000, "toggle_f2");
        check_frame(3, frame_cat(23, 17, 5), 3'b000, "toggle_f3");
      end
      begin
        int unsigned guard = 0;
        while (cyc < 4 * FRAME + 4 && guard < 4000) begin
          @(negedge clk);
          guard++;
          if (cyc % 5 == 0) intf.minutos = (intf.minutos == 6'd17) ? 6'd42 : 6'd17;
        end
      end
    join

    fd_mon = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
